// File: rtl/rl_fifo_pkg.sv
// Shared definitions for the rl FIFO family: read-latency derivation from the
// REGISTERED_OUTPUT setting of the single-clock FIFO.
package rl_fifo_pkg;

  function automatic int rd_latency(string registered_output);
    return (registered_output == "NO") ? 1 : 2;
  endfunction

  function automatic int buf_depth(string registered_output);
    return rd_latency(registered_output) + 1;
  endfunction

endpackage

// File: rtl/rl_fifo_regbuf.sv
// Small circular register buffer: push at tail, pop at head, synchronous clear.
// The head word is always presented on head_o.
module rl_fifo_regbuf #(
  parameter int DEPTH     = 2,
  parameter int DATA_SIZE = 32
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         push_i,
  input  logic [DATA_SIZE-1:0]         data_i,
  input  logic                         pop_i,
  input  logic                         clear_i,
  output logic [DATA_SIZE-1:0]         head_o,
  output logic [$clog2(DEPTH+1)-1:0]   level_o
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int LW = $clog2(DEPTH + 1);

  logic [DATA_SIZE-1:0] mem_q [DEPTH];
  logic [DATA_SIZE-1:0] mem_d [DEPTH];
  logic [PW-1:0]        head_q, head_d, tail_q, tail_d;
  logic [LW-1:0]        level_q, level_d;

  function automatic logic [PW-1:0] wrap_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  always_comb begin
    // NOTE: every variable gets its hold value first so no path leaves it unassigned (no latch); blocking '=' is correct in combinational code.
    mem_d   = mem_q;
    head_d  = head_q;
    tail_d  = tail_q;
    level_d = level_q;
    if (clear_i) begin
      head_d  = '0;
      tail_d  = '0;
      level_d = '0;
    end else begin
      if (push_i) begin
        mem_d[tail_q] = data_i;
        tail_d        = wrap_inc(tail_q);
      end
      if (pop_i) begin
        head_d = wrap_inc(head_q);
      end
      case ({push_i, pop_i})
        2'b10:   level_d = level_q + LW'(1);
        2'b01:   level_d = level_q - LW'(1);
        default: level_d = level_q;
      endcase
    end
  end

  // NOTE: state registers use non-blocking '<=' so every flop samples pre-edge values.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      // NOTE: storage is only a few words, so it is reset as well; q_o then reads zero out of reset.
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      level_q <= '0;
    end else begin
      mem_q   <= mem_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      level_q <= level_d;
    end
  end

  assign head_o  = mem_q[head_q];
  assign level_o = level_q;

  // A capture into a full buffer without a simultaneous pop means the credit logic is broken.
  assert property (@(posedge clk_i) disable iff (!rst_ni)
                   !(push_i && !pop_i && !clear_i && level_q == LW'(DEPTH)));

endmodule

// File: rtl/rl_fifo_fwft.sv
// First-word-fall-through adapter: issues FIFO reads against a credit budget,
// absorbs the FIFO read latency in a register buffer and presents valid/ready.
module rl_fifo_fwft
  import rl_fifo_pkg::*;
#(
  parameter int    DATA_SIZE         = 32,
  parameter string REGISTERED_OUTPUT = "NO",
  localparam int   RD_LATENCY        = rd_latency(REGISTERED_OUTPUT),
  localparam int   BUF_DEPTH         = RD_LATENCY + 1,
  localparam int   LW                = $clog2(BUF_DEPTH + 1)
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 clr_i,
  input  logic                 fifo_empty_i,
  output logic                 fifo_rdena_o,
  input  logic [DATA_SIZE-1:0] fifo_q_i,
  output logic                 valid_o,
  input  logic                 ready_i,
  output logic [DATA_SIZE-1:0] q_o,
  output logic [LW-1:0]        level_o
);

  localparam int CW = LW + 1;

  logic [RD_LATENCY-1:0] rd_sr_q, rd_sr_d;
  logic [CW-1:0]         inflight, credit_used;
  logic                  pop, capture, rdena;

  assign pop     = valid_o & ready_i;
  assign capture = rd_sr_q[RD_LATENCY-1];

  // Words already committed (buffered plus in flight, minus this cycle's pop)
  // must leave room for one more before another read may be issued.
  always_comb begin
    inflight    = CW'($countones(rd_sr_q));
    credit_used = CW'(level_o) + inflight - CW'(pop);
    rdena       = ~fifo_empty_i & ~clr_i & (credit_used < CW'(BUF_DEPTH));
    rd_sr_d     = '0;
    if (!clr_i) begin
      rd_sr_d[0] = rdena;
      for (int i = 1; i < RD_LATENCY; i++) rd_sr_d[i] = rd_sr_q[i-1];
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_sr_q <= '0;
    end else begin
      rd_sr_q <= rd_sr_d;
    end
  end

  rl_fifo_regbuf #(
    .DEPTH     (BUF_DEPTH),
    .DATA_SIZE (DATA_SIZE)
  ) u_regbuf (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (capture),
    .data_i  (fifo_q_i),
    .pop_i   (pop),
    .clear_i (clr_i),
    .head_o  (q_o),
    .level_o (level_o)
  );

  assign valid_o      = (level_o != '0);
  assign fifo_rdena_o = rdena;

endmodule

// File: tb/tb_rl_fifo_fwft.sv
// Bench for rl_fifo_fwft: two instances (read latency 1 and 2), each fed by a
// behavioural FIFO model, with an in-order scoreboard and directed sequences.
module tb_rl_fifo_fwft;
  localparam int DW = 32;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic          clr     [2];
  logic          ready   [2];
  logic          wr_en   [2];
  logic [DW-1:0] wr_data [2];

  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // Channel g: latency g+1, buffer depth g+2. The FIFO model is a queue with a
  // read pipeline; the scoreboard is simply the write order.
  for (genvar g = 0; g < 2; g++) begin : g_ch
    localparam string RO    = (g == 0) ? "NO" : "YES";
    localparam int    DEPTH = g + 2;

    logic          fifo_empty, rdena, valid;
    logic [DW-1:0] fifo_q, q, pipe;
    logic [1:0]    level;
    logic [DW-1:0] fq [$];
    logic [DW-1:0] sb [$];
    int            issued, delivered, pending;
    logic          held_v;
    logic [DW-1:0] held_q;
    logic          rd_fire;
    logic [DW-1:0] rd_word;

    rl_fifo_fwft #(
      .DATA_SIZE         (DW),
      .REGISTERED_OUTPUT (RO)
    ) u_dut (
      .clk_i        (clk),
      .rst_ni       (rst_n),
      .clr_i        (clr[g]),
      .fifo_empty_i (fifo_empty),
      .fifo_rdena_o (rdena),
      .fifo_q_i     (fifo_q),
      .valid_o      (valid),
      .ready_i      (ready[g]),
      .q_o          (q),
      .level_o      (level)
    );

    always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        fq.delete();
        sb.delete();
        issued     = 0;
        delivered  = 0;
        pending    = 0;
        held_v     = 1'b0;
        held_q     = '0;
        fifo_empty <= 1'b1;
        fifo_q     <= '0;
        pipe       <= '0;
      end else begin
        if (held_v) begin
          check("hold_valid", valid, 1'b1);
          check("hold_q", q, held_q);
        end
        held_v = valid && !ready[g] && !clr[g];
        held_q = q;
        if (valid && ready[g]) begin
          if (sb.size() == 0) check("pop_unexpected", valid, 1'b0);
          else check("order", q, sb.pop_front());
          delivered++;
        end
        if (fq.size() == 0) check("rd_on_empty", rdena, 1'b0);
        rd_fire = rdena && (fq.size() != 0);
        rd_word = '0;
        if (rd_fire) begin
          rd_word = fq.pop_front();
          issued++;
        end
        check("outstanding_bound", (issued - delivered <= DEPTH), 1'b1);
        if (g == 0) begin
          if (rd_fire) fifo_q <= rd_word;
        end else begin
          if (rd_fire) pipe <= rd_word;
          fifo_q <= pipe;
        end
        if (wr_en[g]) begin
          fq.push_back(wr_data[g]);
          sb.push_back(wr_data[g]);
        end
        if (clr[g]) begin
          fq.delete();
          sb.delete();
          issued    = 0;
          delivered = 0;
        end
        pending = sb.size();
        fifo_empty <= (fq.size() == 0);
      end
    end
  end

  typedef struct {
    logic          wr;
    logic [DW-1:0] d;
    logic          rdy;
    logic          ev;
    logic [DW-1:0] eq;
    logic [1:0]    el;
    logic          er;
  } vec_t;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs [5];
    int   base_i, base_d;
    logic [3:0] pat;

    // First-word latency, latency-1 channel: write 0x11, then drain.
    vecs[0] = '{1'b1, 32'h11, 1'b1, 1'b0, 32'h0,  2'd0, 1'b0};
    vecs[1] = '{1'b0, 32'h0,  1'b1, 1'b0, 32'h0,  2'd0, 1'b1};
    vecs[2] = '{1'b0, 32'h0,  1'b1, 1'b0, 32'h0,  2'd0, 1'b0};
    vecs[3] = '{1'b0, 32'h0,  1'b1, 1'b1, 32'h11, 2'd1, 1'b0};
    vecs[4] = '{1'b0, 32'h0,  1'b1, 1'b0, 32'h0,  2'd0, 1'b0};

    rst_n = 1'b0;
    for (int g = 0; g < 2; g++) begin
      clr[g] = 1'b0; ready[g] = 1'b0; wr_en[g] = 1'b0; wr_data[g] = '0;
    end
    repeat (2) @(negedge clk);
    check("rst_valid0", g_ch[0].valid, 1'b0);
    check("rst_level0", g_ch[0].level, 2'd0);
    check("rst_rdena0", g_ch[0].rdena, 1'b0);
    check("rst_q0",     g_ch[0].q, 32'h0);
    check("rst_valid1", g_ch[1].valid, 1'b0);
    check("rst_level1", g_ch[1].level, 2'd0);
    check("rst_rdena1", g_ch[1].rdena, 1'b0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      wr_en[0] = vecs[i].wr; wr_data[0] = vecs[i].d; ready[0] = vecs[i].rdy;
      #1;
      check($sformatf("vec%0d_valid", i), g_ch[0].valid, vecs[i].ev);
      check($sformatf("vec%0d_level", i), g_ch[0].level, vecs[i].el);
      check($sformatf("vec%0d_rdena", i), g_ch[0].rdena, vecs[i].er);
      if (vecs[i].ev) check($sformatf("vec%0d_q", i), g_ch[0].q, vecs[i].eq);
    end

    // Burst of 16 at full rate: valid from cycle 3 with no gaps, drops after the last pop.
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      wr_en[0] = (i < 16); wr_data[0] = DW'(i);
      #1;
      if (i >= 3 && i <= 18) begin
        check("burst16_valid", g_ch[0].valid, 1'b1);
        check("burst16_q", g_ch[0].q, DW'(i - 3));
      end
      if (i == 19) check("burst16_drain", g_ch[0].valid, 1'b0);
    end

    // Burst of 8 with ready pattern 1,0,0,1.
    pat = 4'b1001;
    base_d = g_ch[0].delivered;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      ready[0] = pat[c % 4];
      wr_en[0] = (c < 8); wr_data[0] = 32'h20 + DW'(c);
      #1;
      check("burst8_level", (g_ch[0].level <= 2'd2), 1'b1);
      if (c >= 8 && g_ch[0].pending == 0) break;
    end
    @(negedge clk);
    ready[0] = 1'b1; wr_en[0] = 1'b0;
    check("burst8_count", g_ch[0].delivered - base_d, 8);

    // Latency-2 channel stalled with 10 words queued.
    base_i = g_ch[1].issued;
    base_d = g_ch[1].delivered;
    ready[1] = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      wr_en[1] = 1'b1; wr_data[1] = 32'h40 + DW'(i);
    end
    @(negedge clk);
    wr_en[1] = 1'b0;
    repeat (3) begin
      @(negedge clk);
      #1;
      check("stall_rdena", g_ch[1].rdena, 1'b0);
    end
    check("stall_level", g_ch[1].level, 2'd3);
    check("stall_reads", g_ch[1].issued - base_i, 3);
    check("stall_valid", g_ch[1].valid, 1'b1);
    check("stall_head",  g_ch[1].q, 32'h40);
    ready[1] = 1'b1;
    for (int k = 0; k < 40 && g_ch[1].pending != 0; k++) @(negedge clk);
    check("stall_release_count", g_ch[1].delivered - base_d, 10);

    // Flush with two reads in flight and one word buffered.
    repeat (3) @(negedge clk);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      wr_en[1] = 1'b1; wr_data[1] = 32'h60 + DW'(i);
      #1;
      if (g_ch[1].level == 2'd1 && (g_ch[1].issued - g_ch[1].delivered) == 3) break;
    end
    check("clr_precond_level", g_ch[1].level, 2'd1);
    wr_en[1] = 1'b0; clr[1] = 1'b1;
    #1;
    check("clr_rdena", g_ch[1].rdena, 1'b0);
    @(negedge clk);
    clr[1] = 1'b0;
    #1;
    check("clr_valid", g_ch[1].valid, 1'b0);
    check("clr_level", g_ch[1].level, 2'd0);
    repeat (4) @(negedge clk);
    wr_en[1] = 1'b1; wr_data[1] = 32'hAA;
    @(negedge clk);
    wr_en[1] = 1'b0;
    for (int k = 0; k < 8 && !g_ch[1].valid; k++) @(negedge clk);
    check("clr_next_valid", g_ch[1].valid, 1'b1);
    check("clr_next_word",  g_ch[1].q, 32'hAA);
    repeat (3) @(negedge clk);

    // Asynchronous reset in the middle of a burst.
    ready[0] = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      wr_en[0] = 1'b1; wr_data[0] = 32'h80 + DW'(i);
    end
    #1;
    check("prerst_valid", g_ch[0].valid, 1'b1);
    #1;
    rst_n = 1'b0;
    #1;
    check("midrst_valid", g_ch[0].valid, 1'b0);
    check("midrst_level", g_ch[0].level, 2'd0);
    check("midrst_rdena", g_ch[0].rdena, 1'b0);
    @(negedge clk);
    wr_en[0] = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    wr_en[0] = 1'b1; wr_data[0] = 32'h55;
    @(negedge clk);
    wr_data[0] = 32'h56;
    @(negedge clk);
    wr_en[0] = 1'b0;
    for (int k = 0; k < 8 && !g_ch[0].valid; k++) @(negedge clk);
    check("postrst_valid", g_ch[0].valid, 1'b1);
    check("postrst_word",  g_ch[0].q, 32'h55);
    repeat (4) @(negedge clk);

    // Randomised traffic on both channels; the scoreboards check every pop.
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      for (int g = 0; g < 2; g++) begin
        ready[g]   = ($urandom_range(0, 3) != 0);
        clr[g]     = ($urandom_range(0, 149) == 0);
        wr_en[g]   = !clr[g] && ($urandom_range(0, 2) != 0);
        wr_data[g] = $urandom;
      end
    end
    @(negedge clk);
    for (int g = 0; g < 2; g++) begin
      ready[g] = 1'b1; clr[g] = 1'b0; wr_en[g] = 1'b0;
    end
    for (int k = 0; k < 4000 && (g_ch[0].pending != 0 || g_ch[1].pending != 0); k++)
      @(negedge clk);
    repeat (4) @(negedge clk);
    check("rand_drain0", g_ch[0].pending, 0);
    check("rand_drain1", g_ch[1].pending, 0);
    check("rand_idle0",  g_ch[0].valid, 1'b0);
    check("rand_idle1",  g_ch[1].valid, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
